alu_cmd_issuer: RTL



---
 rtl/alu_cmd_issuer.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/alu_cmd_issuer.sv
// Initiator for the 32-bit ALU: takes one command on a valid/ready request port,
// drives the ALU buses for the ALU latency, and returns the result on a valid/ready response port.
module alu_cmd_issuer #(
    parameter int ALU_LAT = 2,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [3:0]       req_op,
    input  logic [31:0]      req_a,
    input  logic [31:0]      req_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_data,
    output logic             rsp_zero,
    output logic             rsp_err,
    output logic [31:0]      alu_a_bus,
    output logic [31:0]      alu_b_bus,
    output logic [3:0]       alu_control,
    output logic             alu_enable,
    input  logic [31:0]      alu_c_bus,
    output logic [CNT_W-1:0] cmd_count
);

    localparam int                WCNT_W    = $clog2(ALU_LAT);
    localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(ALU_LAT - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [WCNT_W-1:0] r_wcnt;
    logic              r_req_ready;
    logic              r_rsp_valid;
    logic [31:0]       r_rsp_data;
    logic              r_rsp_zero;
    logic              r_rsp_err;
    logic [31:0]       r_alu_a_bus;
    logic [31:0]       r_alu_b_bus;
    logic [3:0]        r_alu_control;
    logic              r_alu_enable;
    logic [CNT_W-1:0]  r_cmd_count;

    logic              w_reject;
    logic              w_accept;
    logic              w_wait_done;
    logic              w_rsp_hs;

    // A remainder by zero never terminates inside the ALU, so it is refused here.
    always_comb begin
        w_state_nxt = r_state;
        w_reject    = (req_op == 4'd0) || (req_op > 4'd9) ||
                      ((req_op == 4'd4) && (req_b == 32'd0));
        w_accept    = (r_state == IDLE) && req_valid;
        w_wait_done = (r_state == WAIT) && (r_wcnt == WCNT_LAST);
        w_rsp_hs    = (r_state == RESP) && r_rsp_valid && rsp_ready;
        case (r_state)
            IDLE:    if (w_accept) w_state_nxt = w_reject ? RESP : ISSUE;
            ISSUE:   w_state_nxt = WAIT;
            WAIT:    if (w_wait_done) w_state_nxt = RESP;
            RESP:    if (w_rsp_hs) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wcnt        <= '0;
            r_req_ready   <= 1'b1;
            r_rsp_valid   <= 1'b0;
            r_rsp_data    <= '0;
            r_rsp_zero    <= 1'b0;
            r_rsp_err     <= 1'b0;
            r_alu_a_bus   <= '0;
            r_alu_b_bus   <= '0;
            r_alu_control <= '0;
            r_alu_enable  <= 1'b0;
            r_cmd_count   <= '0;
        end else begin
            r_alu_enable <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_req_ready <= 1'b0;
                        if (w_reject) begin
                            r_rsp_err  <= 1'b1;
                            r_rsp_data <= '0;
                            r_rsp_zero <= 1'b0;
                        end else begin
                            r_alu_a_bus   <= req_a;
                            r_alu_b_bus   <= req_b;
                            r_alu_control <= req_op;
                            r_alu_enable  <= 1'b1;
                        end
                    end
                end
                ISSUE: r_wcnt <= '0;
                WAIT: begin
                    if (w_wait_done) begin
                        r_rsp_data  <= alu_c_bus;
                        r_rsp_zero  <= (alu_c_bus == 32'd0);
                        r_rsp_err   <= 1'b0;
                        r_rsp_valid <= 1'b1;
                    end else begin
                        r_wcnt <= r_wcnt + 1'b1;
                    end
                end
                RESP: begin
                    // A rejected command enters RESP with valid low; raise it one edge later.
                    if (!r_rsp_valid) begin
                        r_rsp_valid <= 1'b1;
                    end else if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_req_ready <= 1'b1;
                        r_cmd_count <= r_cmd_count + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign req_ready   = r_req_ready;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_data    = r_rsp_data;
    assign rsp_zero    = r_rsp_zero;
    assign rsp_err     = r_rsp_err;
    assign alu_a_bus   = r_alu_a_bus;
    assign alu_b_bus   = r_alu_b_bus;
    assign alu_control = r_alu_control;
    assign alu_enable  = r_alu_enable;
    assign cmd_count   = r_cmd_count;

endmodule
